// File: rtl/acs_nway_pkg.sv
// Shared constants and helpers for the N-way add-compare-select unit.
package acs_nway_pkg;

  typedef enum logic {ST_COLLECT, ST_DONE} acs_st_e;

  localparam int     DECAY_SHIFT = 8;
  localparam longint DECAY_RND   = longint'(1) << (DECAY_SHIFT - 1);

  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic longint norm_off(input int acs_bits);
    return longint'(1) << (acs_bits - 2);
  endfunction

endpackage

// File: rtl/acs_nway_if.sv
// Branch-metric input and winner output bundle for acs_nway.
interface acs_nway_if import acs_nway_pkg::*; #(
  parameter int NUM_BRANCH = 4,
  parameter int ACS_BITS   = 12,
  parameter int BM_BITS    = 8,
  parameter int SEL_BITS   = sel_bits(NUM_BRANCH)
) ();
  logic                           symEn;
  logic                           bmValid;
  logic [BM_BITS-1:0]             iBm;
  logic [BM_BITS-1:0]             qBm;
  logic [NUM_BRANCH*ACS_BITS-1:0] accMetIn;
  logic                           normalizeIn;
  logic [7:0]                     decayFactor;
  logic [ACS_BITS-1:0]            accMetOut;
  logic [SEL_BITS-1:0]            selOut;
  logic [BM_BITS-1:0]             iOut;
  logic [BM_BITS-1:0]             qOut;
  logic                           normalizeOut;
  logic                           outValid;
  logic                           missErr;

  modport master (
    output symEn, bmValid, iBm, qBm, accMetIn, normalizeIn, decayFactor,
    input  accMetOut, selOut, iOut, qOut, normalizeOut, outValid, missErr
  );

  modport slave (
    input  symEn, bmValid, iBm, qBm, accMetIn, normalizeIn, decayFactor,
    output accMetOut, selOut, iOut, qOut, normalizeOut, outValid, missErr
  );
endinterface

// File: rtl/acs_cmp2.sv
// One registered compare node; candidate packed as {metric, index, i, q}.
module acs_cmp2 #(
  parameter int ACS_BITS = 12,
  parameter int W        = 30
) (
  input  logic         clk,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  logic signed [ACS_BITS-1:0] ma, mb;
  logic [W-1:0] y_q;

  assign ma  = a_i[W-1 -: ACS_BITS];
  assign mb  = b_i[W-1 -: ACS_BITS];
  assign y_o = y_q;

  // a always carries the lower indices, so >= makes ties go low
  always_ff @(posedge clk) y_q <= (ma >= mb) ? a_i : b_i;
endmodule

// File: rtl/acs_nway.sv
// N-way ACS: serial branch collection, modular add, registered compare tree,
// normalise and optional decay on the winner.
module acs_nway import acs_nway_pkg::*; #(
  parameter int NUM_BRANCH = 4,
  parameter int ACS_BITS   = 12,
  parameter int BM_BITS    = 8,
  parameter int SEL_BITS   = sel_bits(NUM_BRANCH),
  parameter int USE_DECAY  = 0
) (
  input logic       clk,
  input logic       reset,
  acs_nway_if.slave bus
);
  localparam int L      = $clog2(NUM_BRANCH);
  localparam int STAGES = L + 1;
  localparam int W      = ACS_BITS + SEL_BITS + 2*BM_BITS;
  localparam logic [SEL_BITS-1:0]        LAST = SEL_BITS'(NUM_BRANCH - 1);
  localparam logic signed [ACS_BITS-1:0] NORM = ACS_BITS'(norm_off(ACS_BITS));

  acs_st_e st_q, st_d;
  logic [SEL_BITS-1:0] idx_q, idx_d, wr_idx;
  logic wr_en, cap, miss_d, miss_q;

  logic [NUM_BRANCH-2:0][BM_BITS-1:0]  slot_i, slot_q;
  logic [NUM_BRANCH-1:0][BM_BITS-1:0]  snap_i, snap_q;
  logic [NUM_BRANCH-1:0][ACS_BITS-1:0] snap_acc;
  logic [NUM_BRANCH-1:0][W-1:0]        leaf_q;
  logic [NUM_BRANCH-2:0][W-1:0]        tree;
  logic [STAGES:0]                     vld_pipe;

  always_comb begin
    st_d   = st_q;
    idx_d  = idx_q;
    wr_en  = 1'b0;
    wr_idx = idx_q;
    cap    = 1'b0;
    miss_d = 1'b0;
    if (bus.symEn) begin
      miss_d = (st_q == ST_COLLECT) && (idx_q != '0);
      st_d   = ST_COLLECT;
      idx_d  = '0;
      wr_idx = '0;
      if (bus.bmValid) begin
        wr_en = 1'b1;
        idx_d = SEL_BITS'(1);
      end
    end else if (st_q == ST_COLLECT && bus.bmValid) begin
      wr_en = 1'b1;
      if (idx_q == LAST) begin
        cap  = 1'b1;
        st_d = ST_DONE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= ST_COLLECT;
      idx_q    <= '0;
      miss_q   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      st_q     <= st_d;
      idx_q    <= idx_d;
      miss_q   <= miss_d;
      vld_pipe <= {vld_pipe[STAGES-1:0], cap};
    end
  end

  // The last branch bypasses the slots and lands straight in the snapshot
  always_ff @(posedge clk) begin
    if (wr_en && !cap) begin
      slot_i[wr_idx] <= bus.iBm;
      slot_q[wr_idx] <= bus.qBm;
    end
    if (cap) begin
      snap_acc <= bus.accMetIn;
      for (int k = 0; k < NUM_BRANCH-1; k++) begin
        snap_i[k] <= slot_i[k];
        snap_q[k] <= slot_q[k];
      end
      snap_i[NUM_BRANCH-1] <= bus.iBm;
      snap_q[NUM_BRANCH-1] <= bus.qBm;
    end
    for (int k = 0; k < NUM_BRANCH; k++)
      leaf_q[k] <= {snap_acc[k] + ACS_BITS'($signed(snap_i[k])),
                    SEL_BITS'(k), snap_i[k], snap_q[k]};
  end

  // Heap layout: node j compares entries 2j and 2j+1 of {leaves, tree}
  for (genvar j = 0; j < NUM_BRANCH-1; j++) begin : g_node
    logic [W-1:0] a, b;
    if (2*j < NUM_BRANCH) begin : g_leaf
      assign a = leaf_q[2*j];
      assign b = leaf_q[2*j+1];
    end else begin : g_int
      assign a = tree[2*j-NUM_BRANCH];
      assign b = tree[2*j+1-NUM_BRANCH];
    end
    acs_cmp2 #(.ACS_BITS(ACS_BITS), .W(W)) u_cmp (
      .clk(clk), .a_i(a), .b_i(b), .y_o(tree[j])
    );
  end

  logic [W-1:0] root;
  logic signed [ACS_BITS-1:0] best, best_n;
  logic v1_q, nrm1_q;
  logic signed [ACS_BITS-1:0] met1_q;
  logic [SEL_BITS-1:0] sel1_q;
  logic [BM_BITS-1:0] i1_q, q1_q;

  assign root   = tree[NUM_BRANCH-2];
  assign best   = root[W-1 -: ACS_BITS];
  assign best_n = bus.normalizeIn ? best - NORM : best;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      met1_q <= '0;
      sel1_q <= '0;
      i1_q   <= '0;
      q1_q   <= '0;
      nrm1_q <= 1'b0;
    end else begin
      v1_q <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) begin
        met1_q <= best_n;
        sel1_q <= root[2*BM_BITS +: SEL_BITS];
        i1_q   <= root[BM_BITS +: BM_BITS];
        q1_q   <= root[0 +: BM_BITS];
        nrm1_q <= (best[ACS_BITS-1 -: 2] == 2'b01) && !bus.normalizeIn;
      end
    end
  end

  if (USE_DECAY != 0) begin : g_decay
    logic v2_q, nrm2_q;
    logic [ACS_BITS-1:0] met2_q;
    logic [SEL_BITS-1:0] sel2_q;
    logic [BM_BITS-1:0] i2_q, q2_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        v2_q   <= 1'b0;
        met2_q <= '0;
        sel2_q <= '0;
        i2_q   <= '0;
        q2_q   <= '0;
        nrm2_q <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) begin
          met2_q <= ACS_BITS'((longint'(met1_q) * longint'({1'b0, bus.decayFactor})
                               + DECAY_RND) >>> DECAY_SHIFT);
          sel2_q <= sel1_q;
          i2_q   <= i1_q;
          q2_q   <= q1_q;
          nrm2_q <= nrm1_q;
        end
      end
    end

    assign bus.accMetOut    = met2_q;
    assign bus.selOut       = sel2_q;
    assign bus.iOut         = i2_q;
    assign bus.qOut         = q2_q;
    assign bus.normalizeOut = nrm2_q;
    assign bus.outValid     = v2_q;
  end else begin : g_nodecay
    assign bus.accMetOut    = met1_q;
    assign bus.selOut       = sel1_q;
    assign bus.iOut         = i1_q;
    assign bus.qOut         = q1_q;
    assign bus.normalizeOut = nrm1_q;
    assign bus.outValid     = v1_q;
  end

  assign bus.missErr = miss_q;
endmodule

// File: doc/acs_nway.md
# acs_nway

Parametrised add-compare-select unit for the multi-h trellis demodulator. It collects NUM_BRANCH rotated branch metrics, which arrive serially from the rotator, one per valid cycle. Each branch metric is added to its predecessor accumulated metric, and a pipelined compare tree picks the winner. The block outputs the winning accumulated metric, the winner's index, the winner's rotated I/Q and a normalisation request. It replaces the fixed 4-way ACS: branch count, widths and decay are now parameters, and missing-branch detection is new.

## Interface
- NUM_BRANCH, 4: branches per state; power of 2, 2..16.
- ACS_BITS, 12: accumulated-metric width, two's complement.
- BM_BITS, 8: branch-metric (rotated I/Q) width, two's complement; BM_BITS < ACS_BITS.
- SEL_BITS, $clog2(NUM_BRANCH): index width.
- USE_DECAY, 0: 1 enables the decay multiplier path.

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- symEn  in  1  symbol strobe; restarts branch collection
- bmValid  in  1  iBm/qBm valid this cycle
- iBm, qBm  in  BM_BITS  rotated branch metric (I is the metric; Q rides along)
- accMetIn  in  NUM_BRANCH*ACS_BITS  predecessor metrics; branch k at [k*ACS_BITS +: ACS_BITS]
- normalizeIn  in  1  global normalise command for this symbol
- decayFactor  in  8  unsigned Q0.8 forget factor (used only if USE_DECAY)
- accMetOut  out  ACS_BITS  winning metric after normalise/decay
- selOut  out  SEL_BITS  winning branch index
- iOut, qOut  out  BM_BITS  rotated I/Q of the winner
- normalizeOut  out  1  winner near positive overflow
- outValid  out  1  one-cycle pulse; outputs updated
- missErr  out  1  one-cycle pulse; symbol dropped

## Operation
- Collection counter idx (0..NUM_BRANCH-1):
  - symEn sets idx=0.
  - Each bmValid writes iBm/qBm into slot idx, then increments idx.
  - If symEn and bmValid occur in the same cycle, the data goes to slot 0 and idx becomes 1.
- Capture: the bmValid with idx==NUM_BRANCH-1 is the last branch. That edge copies all slots, including the live iBm/qBm, into a snapshot and samples accMetIn. idx then saturates in a DONE state; further bmValid are ignored until symEn.
- Missing branches: symEn while 0<idx<NUM_BRANCH (not DONE) pulses missErr the next cycle. The partial symbol produces no outValid.
- Add: sum_k = sext(iBm_k) + accMetIn_k, taken modulo 2^ACS_BITS (no saturation).
- Compare: a binary tree of log2(NUM_BRANCH) registered stages using a signed compare. On a tie the lower index wins. Index and I/Q travel with each candidate.
- Normalise: if normalizeIn is high at output-register time, accMetOut = best - 2^(ACS_BITS-2); otherwise accMetOut = best.
- normalizeOut = (best[ACS_BITS-1:ACS_BITS-2]==2'b01) && !normalizeIn, registered with the outputs.
- Decay (USE_DECAY=1): accMetOut = round-half-up((normalised best * decayFactor) >> 8), computed as a signed × unsigned product. This adds one register stage. normalizeOut is aligned with accMetOut.

## Timing
- Reset:
  - Outputs: accMetOut, selOut, iOut, qOut, normalizeOut, outValid and missErr are all 0.
  - Internal: idx=0 in COLLECT; all pipeline valids are 0.
- States: COLLECT (idx<NUM_BRANCH) → DONE on the last bmValid; any state → COLLECT on symEn.
- Latency: outValid rises LAT = $clog2(NUM_BRANCH)+2 (+1 if USE_DECAY) cycles after the capture edge. For NUM_BRANCH=4 without decay, that is 4 cycles.
- Throughput: one symbol every NUM_BRANCH cycles minimum. Back-to-back symbols are fully pipelined.
- Outputs hold their values between outValid pulses.
- Reset mid-pipeline flushes all in-flight symbols; no outValid follows reset.

## Structure
- A shared package holds the normalise offset constant (2^(ACS_BITS-2)), the decay rounding constant and the SEL_BITS clog2 helper.
- Sub-module acs_cmp2: one registered 2-input compare node carrying {metric, index, i, q}. It is instantiated NUM_BRANCH-1 times through a generate loop forming the tree.

## Test plan
- N=4, ACS_BITS=12: iBm = 10, 20, 30, 5; accMetIn = 100, 80, 95, 130 → outValid 4 cycles after capture; selOut=3, accMetOut=135, iOut=5.
- Tie: all sums 200 → selOut=0.
- Normalise: best=1100 with normalizeIn=0 → normalizeOut=1, accMetOut=1100. Next symbol with normalizeIn=1, best=1100 → accMetOut=76, normalizeOut=0.
- Wrap: sum 2047+10 → accMetOut=-2039, proving modular addition.
- symEn after only 2 bmValid → missErr pulse, no outValid. Next full symbol is processed normally.
- USE_DECAY=1, decayFactor=128, best=101 → accMetOut=51; latency 5 cycles. Reset asserted mid-pipeline → no outValid afterwards; all outputs read 0.
